// File: rtl/pwm_deadtime_gen_if.sv
// Gate-drive bundle between the timer core and the dead-time stage.
// Master drives controls; slave returns gate drives and status.
interface pwm_deadtime_gen_if #(
    parameter int DT_WIDTH = 8
);
    logic                enable;
    logic                pwm_in;
    logic [DT_WIDTH-1:0] dead_time;
    logic                fault_in;
    logic                fault_clr;
    logic                pwm_hi;
    logic                pwm_lo;
    logic                dt_active;
    logic                fault_latched;

    modport master (
        output enable, pwm_in, dead_time, fault_in, fault_clr,
        input  pwm_hi, pwm_lo, dt_active, fault_latched
    );

    modport slave (
        input  enable, pwm_in, dead_time, fault_in, fault_clr,
        output pwm_hi, pwm_lo, dt_active, fault_latched
    );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low gate pair with programmable dead time
// and a latched fault shutdown, all in the ACLK domain.
module pwm_deadtime_gen #(
    parameter int DT_WIDTH      = 8,
    parameter bit HI_ACTIVE_LOW = 1'b0,
    parameter bit LO_ACTIVE_LOW = 1'b0
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    pwm_deadtime_gen_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        DT_TO_HI,
        HI_ON,
        DT_TO_LO,
        LO_ON,
        FAULT
    } state_t;

    localparam logic [DT_WIDTH-1:0] ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_n;
    logic [DT_WIDTH-1:0] cnt;
    logic [DT_WIDTH-1:0] cnt_n;
    logic                enter_hi;
    logic                enter_lo;
    logic                dt_zero;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    assign dt_zero = (bus.dead_time == '0);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        enter_hi = 1'b0;
        enter_lo = 1'b0;
        if (state == FAULT) begin
            if (bus.fault_clr && !bus.fault_in)
                state_n = IDLE;
        end else if (bus.fault_in) begin
            state_n = FAULT;
        end else if (!bus.enable) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    enter_hi = bus.pwm_in;
                    enter_lo = !bus.pwm_in;
                end
                LO_ON: enter_hi = bus.pwm_in;
                HI_ON: enter_lo = !bus.pwm_in;
                // Reverting input aborts the gap: the other gate never turned on
                DT_TO_HI: begin
                    if (!bus.pwm_in)
                        state_n = LO_ON;
                    else if (cnt == '0)
                        state_n = HI_ON;
                    else
                        cnt_n = cnt - ONE;
                end
                DT_TO_LO: begin
                    if (bus.pwm_in)
                        state_n = HI_ON;
                    else if (cnt == '0)
                        state_n = LO_ON;
                    else
                        cnt_n = cnt - ONE;
                end
                default: state_n = IDLE;
            endcase
            if (enter_hi) begin
                if (dt_zero) begin
                    state_n = HI_ON;
                end else begin
                    state_n = DT_TO_HI;
                    cnt_n   = bus.dead_time - ONE;
                end
            end
            if (enter_lo) begin
                if (dt_zero) begin
                    state_n = LO_ON;
                end else begin
                    state_n = DT_TO_LO;
                    cnt_n   = bus.dead_time - ONE;
                end
            end
        end
    end

    assign bus.pwm_hi        = (state == HI_ON) ^ HI_ACTIVE_LOW;
    assign bus.pwm_lo        = (state == LO_ON) ^ LO_ACTIVE_LOW;
    assign bus.dt_active     = (state == DT_TO_HI) || (state == DT_TO_LO);
    assign bus.fault_latched = (state == FAULT);

endmodule
